// File: rtl/mmc_spi_pkg.sv
// Shared definitions for the MMC/SD SPI master: register map, CTRL bit
// positions and the bit-engine state encoding.
package mmc_spi_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    localparam int CTRL_NCS_BIT   = 0;
    localparam int CTRL_DONE_BIT  = 2;
    localparam int CTRL_BUSY_BIT  = 8;
    localparam int CTRL_CD_BIT    = 9;
    localparam int CTRL_WP_BIT    = 10;
    localparam int CTRL_IRQEN_BIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_t;

endpackage

// File: rtl/mmc_spi_master_sync2.sv
// Generic two-flop synchroniser for slow asynchronous status pins.
module mmc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmc_spi_master.sv
// Avalon-MM SPI master for the MMC/SD socket: byte-wide mode 0 transfers at a
// programmable SCK rate, card-detect / write-protect status and a done IRQ.
module mmc_spi_master
    import mmc_spi_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV = 124
) (
    input  logic        csi_global_clock,
    input  logic        csi_global_reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        ins_irq,
    output logic        mmc_nCS,
    output logic        mmc_SCK,
    output logic        mmc_SDO,
    input  logic        mmc_SDI,
    input  logic        mmc_CD,
    input  logic        mmc_WP
);

    localparam logic [7:0] DIV_RESET = 8'(DEFAULT_DIV);

    spi_state_t state;
    spi_state_t next_state;

    logic [7:0] div_reg;
    logic [7:0] active_div;
    logic [7:0] half_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] rx_data;
    logic       done;
    logic       irqen;
    logic       cd_sync;
    logic       wp_sync;

    logic       busy;
    logic       cnt_zero;
    logic       wr_ctrl;
    logic       wr_data;
    logic       wr_div;
    logic       start_xfer;
    logic       sck_rise;
    logic       sck_fall;
    logic       last_fall;
    logic       unused_wdata;

    assign busy         = (state != ST_IDLE);
    assign cnt_zero     = (half_cnt == 8'd0);
    assign wr_ctrl      = avs_write && (avs_address == REG_CTRL);
    assign wr_data      = avs_write && (avs_address == REG_DATA);
    assign wr_div       = avs_write && (avs_address == REG_DIV);
    assign unused_wdata = ^{avs_writedata[31:16], avs_writedata[14:8]};

    mmc_sync2 u_sync_cd (
        .clk (csi_global_clock),
        .rst (csi_global_reset),
        .d   (mmc_CD),
        .q   (cd_sync)
    );

    mmc_sync2 u_sync_wp (
        .clk (csi_global_clock),
        .rst (csi_global_reset),
        .d   (mmc_WP),
        .q   (wp_sync)
    );

    // Bit-engine state register.
    always_ff @(posedge csi_global_clock) begin
        if (csi_global_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: each half period ends when the counter reaches zero.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (wr_data)  next_state = ST_LOW;
            ST_LOW:  if (cnt_zero) next_state = ST_HIGH;
            ST_HIGH: if (cnt_zero) next_state = (bit_cnt == 3'd7) ? ST_IDLE : ST_LOW;
            default: next_state = ST_IDLE;
        endcase
    end

    // Per-cycle events decoded from the state for the datapath registers.
    always_comb begin
        start_xfer = 1'b0;
        sck_rise   = 1'b0;
        sck_fall   = 1'b0;
        last_fall  = 1'b0;
        case (state)
            ST_IDLE: start_xfer = wr_data;
            ST_LOW:  sck_rise   = cnt_zero;
            ST_HIGH: begin
                sck_fall  = cnt_zero;
                last_fall = cnt_zero && (bit_cnt == 3'd7);
            end
            default: ;
        endcase
    end

    // Shift registers, half-period counter and the registered SCK/SDO pins.
    always_ff @(posedge csi_global_clock) begin
        if (csi_global_reset) begin
            half_cnt   <= 8'd0;
            active_div <= DIV_RESET;
            bit_cnt    <= 3'd0;
            tx_shift   <= 8'd0;
            rx_shift   <= 8'd0;
            rx_data    <= 8'd0;
            mmc_SCK    <= 1'b0;
            mmc_SDO    <= 1'b1;
        end else if (start_xfer) begin
            tx_shift   <= avs_writedata[7:0];
            mmc_SDO    <= avs_writedata[7];
            half_cnt   <= div_reg;
            active_div <= div_reg;
            bit_cnt    <= 3'd0;
        end else if (sck_rise) begin
            mmc_SCK  <= 1'b1;
            rx_shift <= {rx_shift[6:0], mmc_SDI};
            half_cnt <= active_div;
        end else if (sck_fall) begin
            mmc_SCK <= 1'b0;
            if (last_fall) begin
                rx_data <= rx_shift;
                mmc_SDO <= 1'b1;
            end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                tx_shift <= {tx_shift[6:0], 1'b0};
                mmc_SDO  <= tx_shift[6];
                half_cnt <= active_div;
            end
        end else if (busy) begin
            half_cnt <= half_cnt - 8'd1;
        end
    end

    // Software-visible control registers; chip select and divider are frozen while busy.
    always_ff @(posedge csi_global_clock) begin
        if (csi_global_reset) begin
            mmc_nCS <= 1'b1;
            irqen   <= 1'b0;
            done    <= 1'b0;
            div_reg <= DIV_RESET;
            ins_irq <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irqen <= avs_writedata[CTRL_IRQEN_BIT];
                if (!busy) begin
                    mmc_nCS <= avs_writedata[CTRL_NCS_BIT];
                end
            end
            if (last_fall) begin
                done <= 1'b1;
            end else if (start_xfer) begin
                done <= 1'b0;
            end else if (wr_ctrl && avs_writedata[CTRL_DONE_BIT]) begin
                done <= 1'b0;
            end
            if (wr_div && !busy) begin
                div_reg <= avs_writedata[7:0];
            end
            ins_irq <= done && irqen;
        end
    end

    // Zero-wait read mux; the bus sees zero whenever it is not reading.
    always_comb begin
        avs_readdata = 32'd0;
        if (avs_read) begin
            case (avs_address)
                REG_CTRL: begin
                    avs_readdata[CTRL_NCS_BIT]   = mmc_nCS;
                    avs_readdata[CTRL_DONE_BIT]  = done;
                    avs_readdata[CTRL_BUSY_BIT]  = busy;
                    avs_readdata[CTRL_CD_BIT]    = cd_sync;
                    avs_readdata[CTRL_WP_BIT]    = wp_sync;
                    avs_readdata[CTRL_IRQEN_BIT] = irqen;
                end
                REG_DATA: avs_readdata = {24'd0, rx_data};
                REG_DIV:  avs_readdata = {24'd0, div_reg};
                default:  avs_readdata = 32'd0;
            endcase
        end
    end

endmodule
